// File: rtl/redundancy_pkg.sv
// Shared definitions for the redundancy (TMR) blocks: word-vote selector and width defaults.
package redundancy_pkg;

  // Word-level voting strategy; BITWISE falls back to a per-bit majority.
  typedef enum logic [1:0] {
    BITWISE = 2'd0,
    KP_AB   = 2'd1,
    AC      = 2'd2,
    BC      = 2'd3
  } voter_type_e;

  localparam int DEFAULT_DATA_WIDTH = 1;
  localparam int DEFAULT_CNT_WIDTH  = 8;

endpackage

// File: rtl/tmr_majority_voter_fail_if.sv
// Bundle of the three replicas, the voted result, the fault flags and the monitor controls.
interface tmr_majority_voter_fail_if #(
  parameter int DataWidth = 1,
  parameter int CntWidth  = 8
);

  logic [DataWidth-1:0] a_i;
  logic [DataWidth-1:0] b_i;
  logic [DataWidth-1:0] c_i;
  logic                 clear_i;
  logic [DataWidth-1:0] majority_o;
  logic                 fault_detected_o;
  logic [2:0]           lane_err_o;
  logic                 multi_fault_o;
  logic                 fault_sticky_o;
  logic [CntWidth-1:0]  fault_cnt_o;

  // Side that supplies the replicas and consumes the vote.
  modport master (
    output a_i, b_i, c_i, clear_i,
    input  majority_o, fault_detected_o, lane_err_o, multi_fault_o,
    input  fault_sticky_o, fault_cnt_o
  );

  // The voter itself.
  modport slave (
    input  a_i, b_i, c_i, clear_i,
    output majority_o, fault_detected_o, lane_err_o, multi_fault_o,
    output fault_sticky_o, fault_cnt_o
  );

endinterface

// File: rtl/tmr_majority_bit.sv
// One-bit 2-of-3 majority with disagreement and minority-lane indication.
module tmr_majority_bit (
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  output logic       maj_o,
  output logic       mismatch_o,
  output logic [2:0] minority_o
);

  assign maj_o      = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign mismatch_o = (a_i ^ b_i) | (a_i ^ c_i);

  // A lane is the minority when the other two agree and it differs from them.
  assign minority_o[0] = ~(b_i ^ c_i) & (a_i ^ b_i);
  assign minority_o[1] = ~(a_i ^ c_i) & (b_i ^ a_i);
  assign minority_o[2] = ~(a_i ^ b_i) & (c_i ^ a_i);

endmodule

// File: rtl/tmr_majority_voter_fail.sv
// TMR voter: zero-latency vote and fault flags, plus a clocked sticky flag and saturating fault counter.
module tmr_majority_voter_fail
  import redundancy_pkg::*;
#(
  parameter int DataWidth = DEFAULT_DATA_WIDTH,
  parameter int Bitwise   = 0,
  parameter int VoterType = 1,
  parameter int CntWidth  = DEFAULT_CNT_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  tmr_majority_voter_fail_if.slave  bus
);

  localparam voter_type_e VT = voter_type_e'(VoterType[1:0]);

  logic [DataWidth-1:0] bit_maj;
  logic [DataWidth-1:0] bit_mis;
  logic [DataWidth-1:0] min_a;
  logic [DataWidth-1:0] min_b;
  logic [DataWidth-1:0] min_c;

  logic eq_ab;
  logic eq_ac;
  logic eq_bc;

  logic                 fault_sticky_q;
  logic [CntWidth-1:0]  fault_cnt_q;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v, input logic inc);
    if (inc && (v != {CntWidth{1'b1}})) begin
      return v + CntWidth'(1);
    end
    return v;
  endfunction

  for (genvar k = 0; k < DataWidth; k++) begin : g_bit
    logic [2:0] minority;
    tmr_majority_bit u_bit (
      .a_i        (bus.a_i[k]),
      .b_i        (bus.b_i[k]),
      .c_i        (bus.c_i[k]),
      .maj_o      (bit_maj[k]),
      .mismatch_o (bit_mis[k]),
      .minority_o (minority)
    );
    assign min_a[k] = minority[0];
    assign min_b[k] = minority[1];
    assign min_c[k] = minority[2];
  end

  assign eq_ab = (bus.a_i == bus.b_i);
  assign eq_ac = (bus.a_i == bus.c_i);
  assign eq_bc = (bus.b_i == bus.c_i);

  // Select the per-bit or word-level result and derive the fault flags.
  always_comb begin
    bus.majority_o       = bit_maj;
    bus.fault_detected_o = 1'b0;
    bus.lane_err_o       = 3'b000;
    bus.multi_fault_o    = 1'b0;
    if (Bitwise != 0) begin
      bus.majority_o       = bit_maj;
      bus.fault_detected_o = |bit_mis;
      bus.lane_err_o       = {|min_c, |min_b, |min_a};
      // A per-bit 3-way vote always resolves, so there is never an uncorrectable word.
      bus.multi_fault_o    = 1'b0;
    end else begin
      case (VT)
        KP_AB:   bus.majority_o = eq_ab ? bus.a_i : bus.c_i;
        AC:      bus.majority_o = eq_ac ? bus.a_i : bus.b_i;
        BC:      bus.majority_o = eq_bc ? bus.b_i : bus.a_i;
        default: bus.majority_o = bit_maj;
      endcase
      bus.fault_detected_o = ~eq_ab | ~eq_ac;
      bus.multi_fault_o    = ~eq_ab & ~eq_ac & ~eq_bc;
      if (bus.multi_fault_o) begin
        // No pair agrees: every lane is suspect.
        bus.lane_err_o = 3'b111;
      end else begin
        bus.lane_err_o = {eq_ab & ~eq_ac, eq_ac & ~eq_ab, eq_bc & ~eq_ab};
      end
    end
  end

  // Fault monitor: reset wins, clear restarts from the current cycle, otherwise accumulate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_sticky_q <= 1'b0;
      fault_cnt_q    <= '0;
    end else if (bus.clear_i) begin
      fault_sticky_q <= bus.fault_detected_o;
      fault_cnt_q    <= CntWidth'(bus.fault_detected_o);
    end else begin
      fault_sticky_q <= fault_sticky_q | bus.fault_detected_o;
      fault_cnt_q    <= sat_inc(fault_cnt_q, bus.fault_detected_o);
    end
  end

  assign bus.fault_sticky_o = fault_sticky_q;
  assign bus.fault_cnt_o    = fault_cnt_q;

endmodule

// File: tb/tb_tmr_majority_voter_fail.sv
// Bench for tmr_majority_voter_fail: five 8-bit voters (word VT 0..3 and bitwise) against a reference model.
module tb_tmr_majority_voter_fail;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int N  = 5;   // index 0..3: word mode VoterType=index, 4: bitwise

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b, c;
  logic         clr;

  logic [W-1:0]  maj_w   [N];
  logic          flt_w   [N];
  logic [2:0]    lane_w  [N];
  logic          multi_w [N];
  logic          stk_w   [N];
  logic [CW-1:0] cnt_w   [N];

  int n_chk  = 0;
  int n_pass = 0;

  int m_stk = 0;
  int m_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    tmr_majority_voter_fail_if #(.DataWidth(W), .CntWidth(CW)) bus ();
    assign bus.a_i     = a;
    assign bus.b_i     = b;
    assign bus.c_i     = c;
    assign bus.clear_i = clr;
    tmr_majority_voter_fail #(
      .DataWidth (W),
      .Bitwise   ((g == 4) ? 1 : 0),
      .VoterType ((g == 4) ? 0 : g),
      .CntWidth  (CW)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
    );
    assign maj_w[g]   = bus.majority_o;
    assign flt_w[g]   = bus.fault_detected_o;
    assign lane_w[g]  = bus.lane_err_o;
    assign multi_w[g] = bus.multi_fault_o;
    assign stk_w[g]   = bus.fault_sticky_o;
    assign cnt_w[g]   = bus.fault_cnt_o;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Per-bit majority by counting ones in each column.
  function automatic logic [W-1:0] ref_bitmaj(input logic [W-1:0] x, y, z);
    logic [W-1:0] r;
    for (int k = 0; k < W; k++) begin
      int s;
      s = int'(x[k]) + int'(y[k]) + int'(z[k]);
      r[k] = (s >= 2);
    end
    return r;
  endfunction

  function automatic int ref_distinct(input logic [W-1:0] x, y, z);
    int d;
    d = 1;
    if (y != x) d++;
    if (z != x && z != y) d++;
    return d;
  endfunction

  function automatic logic [W-1:0] ref_word_maj(input int vt, input logic [W-1:0] x, y, z);
    case (vt)
      1:       return (x == y) ? x : z;
      2:       return (x == z) ? x : y;
      3:       return (y == z) ? y : x;
      default: return ref_bitmaj(x, y, z);
    endcase
  endfunction

  // Word mode: a lane is blamed when the other two are equal and it is not.
  function automatic logic [2:0] ref_word_lane(input logic [W-1:0] x, y, z);
    logic [2:0] l;
    if (ref_distinct(x, y, z) == 3) return 3'b111;
    l[0] = (y == z) && (x != y);
    l[1] = (x == z) && (y != x);
    l[2] = (x == y) && (z != x);
    return l;
  endfunction

  // Bitwise mode: a lane is blamed when any of its bits disagrees with that column's majority.
  function automatic logic [2:0] ref_bit_lane(input logic [W-1:0] x, y, z);
    logic [W-1:0] m;
    m = ref_bitmaj(x, y, z);
    return {|(z ^ m), |(y ^ m), |(x ^ m)};
  endfunction

  task automatic drive(input logic [W-1:0] ta, tb_v, tc, input logic tclr, trst);
    logic         fault;
    logic [W-1:0] em;
    logic [2:0]   el;
    logic         emu;
    a = ta; b = tb_v; c = tc; clr = tclr; rst = trst;
    #1;
    fault = (ref_distinct(a, b, c) != 1);
    for (int g = 0; g < N; g++) begin
      if (g == 4) begin
        em = ref_bitmaj(a, b, c); el = ref_bit_lane(a, b, c); emu = 1'b0;
      end else begin
        em = ref_word_maj(g, a, b, c); el = ref_word_lane(a, b, c); emu = (ref_distinct(a, b, c) == 3);
      end
      chk($sformatf("maj[%0d] a=%h b=%h c=%h", g, a, b, c), int'(maj_w[g]), int'(em));
      chk($sformatf("fault[%0d] a=%h b=%h c=%h", g, a, b, c), int'(flt_w[g]), int'(fault));
      chk($sformatf("lane[%0d] a=%h b=%h c=%h", g, a, b, c), int'(lane_w[g]), int'(el));
      chk($sformatf("multi[%0d] a=%h b=%h c=%h", g, a, b, c), int'(multi_w[g]), int'(emu));
    end
  endtask

  task automatic tick();
    int fault;
    fault = (ref_distinct(a, b, c) != 1) ? 1 : 0;
    @(posedge clk);
    if (rst) begin
      m_stk = 0; m_cnt = 0;
    end else if (clr) begin
      m_stk = fault; m_cnt = fault;
    end else begin
      m_stk = (m_stk != 0 || fault != 0) ? 1 : 0;
      m_cnt = (m_cnt + fault > 255) ? 255 : m_cnt + fault;
    end
    #1;
    for (int g = 0; g < N; g++) begin
      chk($sformatf("sticky[%0d]", g), int'(stk_w[g]), m_stk);
      chk($sformatf("cnt[%0d]", g), int'(cnt_w[g]), m_cnt);
    end
  endtask

  task automatic step(input logic [W-1:0] ta, tb_v, tc, input logic tclr, trst);
    drive(ta, tb_v, tc, tclr, trst);
    tick();
  endtask

  initial begin
    a = '0; b = '0; c = '0; clr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    // Reset with a fault present: monitor zero, vote still live.
    step(8'h00, 8'hFF, 8'hFF, 1'b0, 1'b1);
    chk("reset_cnt", int'(cnt_w[1]), 0);
    chk("reset_sticky", int'(stk_w[1]), 0);

    // All agree.
    drive(8'h5A, 8'h5A, 8'h5A, 1'b0, 1'b0);
    chk("agree_maj", int'(maj_w[1]), 8'h5A);
    chk("agree_fault", int'(flt_w[1]), 0);
    chk("agree_lane", int'(lane_w[1]), 0);
    tick();
    chk("agree_sticky", int'(stk_w[1]), 0);

    // Single lane a corrupted.
    drive(8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);
    chk("lane_a_maj", int'(maj_w[1]), 8'hFF);
    chk("lane_a_lane", int'(lane_w[1]), 3'b001);
    chk("lane_a_multi", int'(multi_w[1]), 0);
    tick();
    chk("lane_a_sticky", int'(stk_w[1]), 1);
    chk("lane_a_cnt", int'(cnt_w[1]), 1);

    // No two replicas agree.
    drive(8'h01, 8'h02, 8'h04, 1'b0, 1'b0);
    chk("multi_vt1", int'(maj_w[1]), 8'h04);
    chk("multi_vt2", int'(maj_w[2]), 8'h02);
    chk("multi_vt3", int'(maj_w[3]), 8'h01);
    chk("multi_vt0", int'(maj_w[0]), 8'h00);
    chk("multi_flag", int'(multi_w[1]), 1);
    chk("multi_lane", int'(lane_w[1]), 3'b111);
    tick();

    // Bitwise resolves every column.
    drive(8'hF0, 8'h0F, 8'h3C, 1'b0, 1'b0);
    chk("bw_maj", int'(maj_w[4]), 8'h3C);
    chk("bw_fault", int'(flt_w[4]), 1);
    chk("bw_multi", int'(multi_w[4]), 0);
    tick();

    // Clear with no fault.
    step(8'h33, 8'h33, 8'h33, 1'b1, 1'b0);
    chk("clear_idle_cnt", int'(cnt_w[1]), 0);
    chk("clear_idle_sticky", int'(stk_w[1]), 0);

    // Long fault saturates the counter.
    for (int i = 0; i < 300; i++) step(8'h12, 8'h12, 8'h13, 1'b0, 1'b0);
    chk("sat_cnt", int'(cnt_w[1]), 255);
    step(8'h12, 8'h12, 8'h13, 1'b0, 1'b0);
    chk("sat_hold", int'(cnt_w[1]), 255);

    // Clear during a fault keeps that cycle's fault.
    step(8'h12, 8'h99, 8'h12, 1'b1, 1'b0);
    chk("clear_fault_cnt", int'(cnt_w[1]), 1);
    chk("clear_fault_sticky", int'(stk_w[1]), 1);

    // Reset mid-operation during a fault.
    step(8'hAA, 8'h55, 8'h55, 1'b0, 1'b0);
    drive(8'hAA, 8'hAA, 8'h55, 1'b0, 1'b1);
    chk("rst_mid_maj", int'(maj_w[1]), 8'hAA);
    tick();
    chk("rst_mid_cnt", int'(cnt_w[1]), 0);
    chk("rst_mid_sticky", int'(stk_w[1]), 0);

    // Random replicas with at most one lane corrupted.
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] base, bad, ra, rb, rc;
      int lane;
      base = W'($urandom);
      bad  = base ^ W'($urandom_range(1, 255));
      lane = $urandom_range(0, 3);
      ra = (lane == 0) ? bad : base;
      rb = (lane == 1) ? bad : base;
      rc = (lane == 2) ? bad : base;
      step(ra, rb, rc, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
